// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue with CTI pre-decode
// Multi-lane enqueue, single issue, flush with optional branch-delay-slot retention.
module inst_queue #(
  parameter int DEPTH     = 8,
  parameter int ENQ_WIDTH = 2,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(ENQ_WIDTH+1)-1:0] enq_num,
  input  logic [32*ENQ_WIDTH-1:0]       enq_inst,
  input  logic [31:0]                   enq_pc,
  input  logic                          enq_exc,
  output logic                          enq_ready,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [31:0]                   deq_inst,
  output logic [31:0]                   deq_pc,
  output logic                          deq_exc,
  output logic                          deq_is_cti,
  input  logic                          flush,
  input  logic                          flush_keep_ds,
  output logic [PTR_W:0]                count
);

  typedef logic [PTR_W:0] ptr_t;

  localparam ptr_t LP_READY_MAX = ptr_t'(DEPTH - ENQ_WIDTH);
  localparam ptr_t LP_ONE       = ptr_t'(1);

  function automatic logic f_is_cti(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    return (op == 6'b000001) || (op[5:1] == 5'b00001) || (op[5:2] == 4'b0001) ||
           ((op == 6'b000000) && (fn[5:1] == 5'b00100));
  endfunction

  logic [31:0] r_inst [DEPTH];
  logic [31:0] r_pc   [DEPTH];
  logic        r_exc  [DEPTH];
  logic        r_cti  [DEPTH];

  ptr_t r_rptr;
  ptr_t r_wptr;
  logic r_ds_pend;

  ptr_t                 w_count;
  logic                 w_deq_fire;
  logic                 w_enq_fire;
  ptr_t                 w_rptr_nx;
  ptr_t                 w_wptr_nx;
  ptr_t                 w_left;
  logic                 w_pend_nx;
  ptr_t                 w_n_wr;
  logic [ENQ_WIDTH-1:0] w_wr_en;
  ptr_t                 w_lane_ptr [ENQ_WIDTH];
  logic [31:0]          w_lane_pc  [ENQ_WIDTH];

  assign w_count    = r_wptr - r_rptr;
  assign count      = w_count;
  assign enq_ready  = (w_count <= LP_READY_MAX);
  assign deq_valid  = (w_count != '0);
  assign w_deq_fire = deq_valid && deq_ready;
  assign w_enq_fire = (enq_num != '0) && enq_ready;
  assign w_rptr_nx  = r_rptr + ptr_t'(w_deq_fire);
  assign w_left     = w_count - ptr_t'(w_deq_fire);

  assign deq_inst   = r_inst[r_rptr[PTR_W-1:0]];
  assign deq_pc     = r_pc[r_rptr[PTR_W-1:0]];
  assign deq_exc    = r_exc[r_rptr[PTR_W-1:0]];
  assign deq_is_cti = r_cti[r_rptr[PTR_W-1:0]];

  // Flush outranks enqueue; a kept delay slot is either the oldest survivor or new lane 0.
  always_comb begin
    w_wptr_nx = r_wptr;
    w_pend_nx = r_ds_pend;
    w_n_wr    = '0;
    if (flush) begin
      if (!flush_keep_ds) begin
        w_wptr_nx = w_rptr_nx;
        w_pend_nx = 1'b0;
      end else if (w_left != '0) begin
        w_wptr_nx = w_rptr_nx + LP_ONE;
      end else if (w_enq_fire) begin
        w_n_wr    = LP_ONE;
        w_wptr_nx = r_wptr + LP_ONE;
        w_pend_nx = 1'b0;
      end else begin
        w_wptr_nx = w_rptr_nx;
        w_pend_nx = 1'b1;
      end
    end else if (w_enq_fire) begin
      if (r_ds_pend) begin
        w_n_wr    = LP_ONE;
        w_wptr_nx = r_wptr + LP_ONE;
        w_pend_nx = 1'b0;
      end else begin
        w_n_wr    = ptr_t'(enq_num);
        w_wptr_nx = r_wptr + ptr_t'(enq_num);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      w_wr_en[i]    = (ptr_t'(i) < w_n_wr);
      w_lane_ptr[i] = r_wptr + ptr_t'(i);
      w_lane_pc[i]  = enq_pc + 32'(4 * i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_ds_pend <= 1'b0;
    end else begin
      r_rptr    <= w_rptr_nx;
      r_wptr    <= w_wptr_nx;
      r_ds_pend <= w_pend_nx;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (w_wr_en[i]) begin
        r_inst[w_lane_ptr[i][PTR_W-1:0]] <= enq_inst[32*i +: 32];
        r_pc[w_lane_ptr[i][PTR_W-1:0]]   <= w_lane_pc[i];
        r_exc[w_lane_ptr[i][PTR_W-1:0]]  <= enq_exc;
        r_cti[w_lane_ptr[i][PTR_W-1:0]]  <= f_is_cti(enq_inst[32*i +: 32]);
      end
    end
  end

endmodule
